// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_pkg
// Brief    : Shared types and widths for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

   localparam int DATA_W    = 32;
   localparam int BE_W      = 4;
   localparam int LAT_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : Single-port word RAM, byte write enables, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [BE_W-1:0]   i_be,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (i_be[b]) begin
               r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/dmem_wait_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wait_responder
// Brief    : Slow data-RAM responder holding waitrequest for LATENCY+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_wait_responder
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       i_p_addr,
   input  logic              i_p_read,
   input  logic              i_p_write,
   input  logic [31:0]       i_p_writedata,
   input  logic [3:0]        i_p_byteenable,
   output logic [31:0]       o_p_readdata,
   output logic              o_p_waitrequest
);

   localparam logic [LAT_CNT_W-1:0] c_LAT_INIT = LAT_CNT_W'(LATENCY - 1);

   dmem_state_e          r_state;
   dmem_state_e          w_state_nxt;
   logic [LAT_CNT_W-1:0] r_cnt;
   logic [LAT_CNT_W-1:0] w_cnt_nxt;
   logic [DATA_W-1:0]    r_readdata;
   logic [DATA_W-1:0]    w_mem_rdata;
   logic [ADDR_W-1:0]    w_word_addr;
   logic                 w_req;
   logic                 w_capture;
   logic                 w_mem_we;
   logic                 w_unused_addr;

   // Only the word-select bits matter; the rest alias.
   assign w_word_addr   = i_p_addr[ADDR_W+1:2];
   assign w_unused_addr = ^{i_p_addr[31:ADDR_W+2], i_p_addr[1:0]};

   assign w_req           = i_p_read | i_p_write;
   assign o_p_waitrequest = w_req & (r_state != DONE);
   assign o_p_readdata    = r_readdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_readdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_capture) begin
            r_readdata <= w_mem_rdata;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_mem_we    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_state_nxt = BUSY;
               w_cnt_nxt   = c_LAT_INIT;
            end
         end
         BUSY: begin
            if (!w_req) begin
               w_state_nxt = IDLE;
            end else if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else begin
               w_state_nxt = DONE;
               // A combined read+write is a write; readdata stays put.
               w_capture   = ~i_p_write;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_mem_we    = w_req & i_p_write;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_dmem_array (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_be    (i_p_byteenable),
      .i_addr  (w_word_addr),
      .i_wdata (i_p_writedata),
      .o_rdata (w_mem_rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_dmem_wait_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_wait_responder
// Brief    : Randomized bench for dmem_wait_responder (LATENCY 2 and 1 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_wait_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] p_addr;
   logic [31:0] p_wdata;
   logic [3:0]  p_be;
   logic        p_rd;
   logic        p_wr;
   int          dsel;

   logic        rd0, wr0, rd1, wr1;
   logic [31:0] rdata0, rdata1;
   logic        wait0, wait1;
   logic [31:0] rdata_sel;
   logic        wait_sel;

   int          n_chk  = 0;
   int          n_fail = 0;

   logic [31:0] mm [2][1024];
   logic [31:0] last_rd [2];
   logic [9:0]  pool [2][12];

   always #5 clk = ~clk;

   assign rd0 = p_rd && (dsel == 0);
   assign wr0 = p_wr && (dsel == 0);
   assign rd1 = p_rd && (dsel == 1);
   assign wr1 = p_wr && (dsel == 1);
   assign rdata_sel = (dsel == 0) ? rdata0 : rdata1;
   assign wait_sel  = (dsel == 0) ? wait0  : wait1;

   dmem_wait_responder #(.ADDR_W(10), .LATENCY(2)) u_dut_l2 (
      .clk             (clk),
      .rst             (rst),
      .i_p_addr        (p_addr),
      .i_p_read        (rd0),
      .i_p_write       (wr0),
      .i_p_writedata   (p_wdata),
      .i_p_byteenable  (p_be),
      .o_p_readdata    (rdata0),
      .o_p_waitrequest (wait0)
   );

   dmem_wait_responder #(.ADDR_W(10), .LATENCY(1)) u_dut_l1 (
      .clk             (clk),
      .rst             (rst),
      .i_p_addr        (p_addr),
      .i_p_read        (rd1),
      .i_p_write       (wr1),
      .i_p_writedata   (p_wdata),
      .i_p_byteenable  (p_be),
      .o_p_readdata    (rdata1),
      .o_p_waitrequest (wait1)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One complete access on the selected DUT, held until accepted.
   task automatic access(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int          stall;
      int          lat;
      logic [9:0]  w;
      logic [31:0] m;
      lat = (sel == 0) ? 2 : 1;
      w   = a[11:2];
      @(posedge clk); #1;
      dsel = sel; p_addr = a; p_wdata = d; p_be = be; p_rd = rd; p_wr = wr;
      stall = 0;
      while (stall < 20) begin
         @(negedge clk);
         if (!wait_sel) break;
         stall++;
      end
      chk_eq("stall_cycles", stall, lat + 1);
      if (!wr) last_rd[sel] = mm[sel][w];
      chk_eq(wr ? "rdata_hold_on_write" : "rdata_done", rdata_sel, last_rd[sel]);
      @(posedge clk); #1;
      p_rd = 1'b0; p_wr = 1'b0;
      if (wr) begin
         m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
         mm[sel][w] = (mm[sel][w] & ~m) | (d & m);
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] a;
      int          op;
      rst = 1'b0; p_addr = '0; p_wdata = '0; p_be = '0; p_rd = 1'b0; p_wr = 1'b0; dsel = 0;
      last_rd[0] = '0; last_rd[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_eq("reset_rdata0", rdata0, 32'h0);
      chk_eq("reset_wait0", {31'b0, wait0}, 32'h0);
      chk_eq("reset_rdata1", rdata1, 32'h0);
      rst = 1'b1;

      // Directed: full write, partial write, combined read+write.
      access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      chk_eq("deadbeef", rdata0, 32'hDEADBEEF);
      access(0, 1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
      access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      chk_eq("deadbeaa", rdata0, 32'hDEADBEAA);
      access(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
      access(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      chk_eq("combined_wr", rdata0, 32'h12345678);
      access(0, 1'b0, 1'b1, 32'h10, 32'h77777777, 4'h0);
      access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      chk_eq("be_zero", rdata0, 32'hDEADBEAA);

      // Write dropped after one BUSY cycle.
      @(posedge clk); #1;
      dsel = 0; p_addr = 32'h10; p_wdata = 32'hFFFFFFFF; p_be = 4'hF; p_wr = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      p_wr = 1'b0;
      @(negedge clk);
      chk_eq("drop_wait", {31'b0, wait0}, 32'h0);
      chk_eq("drop_rdata", rdata0, last_rd[0]);
      access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);

      // Reset asserted during a BUSY write.
      access(0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
      access(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
      @(posedge clk); #1;
      dsel = 0; p_addr = 32'h30; p_wdata = 32'h11111111; p_be = 4'hF; p_wr = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      #1 chk_eq("midreset_rdata", rdata0, 32'h0);
      p_wr = 1'b0;
      #1 chk_eq("midreset_wait", {31'b0, wait0}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      last_rd[0] = '0; last_rd[1] = '0;
      access(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
      chk_eq("midreset_mem", rdata0, 32'hCAFEF00D);

      // LATENCY=1 build: address alias of word 0.
      access(1, 1'b0, 1'b1, 32'h0, 32'h55, 4'hF);
      access(1, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
      chk_eq("alias_word0", rdata1, 32'h55);

      // Randomized traffic against the reference model.
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 12; i++) begin
            r = $urandom();
            pool[s][i] = r[9:0];
            access(s, 1'b0, 1'b1, {20'h0, r[9:0], 2'b00}, $urandom(), 4'hF);
         end
      end
      for (int k = 0; k < 60; k++) begin
         int s;
         int i;
         s  = (k % 4 == 3) ? 1 : 0;
         i  = $urandom_range(0, 11);
         op = $urandom_range(0, 3);
         r  = $urandom();
         a  = {r[31:12], pool[s][i], r[1:0]};
         r  = $urandom();
         access(s, op != 2, op >= 2, a, $urandom(), r[3:0]);
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
